// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair: shift-add multiply and
// restoring divide on operand magnitudes, one bit per cycle, sign fix-up on exit.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               is_div, neg_lo, neg_hi, div0, done_r;
  logic [WIDTH-1:0]   hi_r, lo_r;

  logic               launch, signed_op, s1, s2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     msum, shifted;
  logic               ge;
  logic [WIDTH-1:0]   rem_nx;
  logic [2*WIDTH-1:0] step_nx, prod;
  logic [WIDTH-1:0]   res_hi, res_lo, quo, rem;

  assign launch    = (state == IDLE) && start && !mthi && !mtlo;
  assign signed_op = ~op[0];
  assign s1        = signed_op & data1[WIDTH-1];
  assign s2        = signed_op & data2[WIDTH-1];
  // Magnitudes are kept unsigned, so |0x80000000| fits without truncation.
  assign mag1      = s1 ? -data1 : data1;
  assign mag2      = s2 ? -data2 : data2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (launch) state_nx = RUN;
      RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {remainder, dividend bits shifting into quotient bits}.
  always_comb begin
    msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge      = shifted >= {1'b0, opnd};
    rem_nx  = ge ? (shifted[WIDTH-1:0] - opnd) : shifted[WIDTH-1:0];
    if (is_div) step_nx = {rem_nx, acc[WIDTH-2:0], ge};
    else        step_nx = {msum, acc[WIDTH-1:1]};
  end

  always_comb begin
    prod = neg_lo ? -acc : acc;
    quo  = acc[WIDTH-1:0];
    rem  = acc[2*WIDTH-1:WIDTH];
    if (is_div) begin
      // Divide by zero leaves the dividend magnitude in rem; its sign fix-up restores data1.
      res_lo = div0 ? '1 : (neg_lo ? -quo : quo);
      res_hi = neg_hi ? -rem : rem;
    end else begin
      res_lo = prod[WIDTH-1:0];
      res_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      div0   <= 1'b0;
      done_r <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      done_r <= (state == FINISH);
      if (launch) begin
        cnt    <= '0;
        is_div <= op[1];
        neg_lo <= s1 ^ s2;
        neg_hi <= s1;
        div0   <= op[1] && (data2 == '0);
        if (op[1]) begin
          acc  <= {{WIDTH{1'b0}}, mag1};
          opnd <= mag2;
        end else begin
          acc  <= {{WIDTH{1'b0}}, mag2};
          opnd <= mag1;
        end
      end else if (state == RUN) begin
        acc <= step_nx;
        cnt <= cnt + 1'b1;
      end
      if (state == FINISH) begin
        hi_r <= res_hi;
        lo_r <= res_lo;
      end else if (state == IDLE) begin
        if (mthi) hi_r <= data1;
        if (mtlo) lo_r <= data1;
      end
    end
  end

  assign hi   = hi_r;
  assign lo   = lo_r;
  assign busy = (state != IDLE);
  assign done = done_r;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit for the single-cycle CPU datapath. Owns the HI/LO register pair.
- Takes the two register-file operands as inputs. Its hi/lo outputs feed the writeback-side 32-bit 2:1 result select for MFHI/MFLO.
- Raises busy so the control unit can stall the PC while an operation runs.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  launch the operation given by op; sampled only in IDLE.
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- data1  input  WIDTH  rs operand: multiplicand / dividend.
- data2  input  WIDTH  rt operand: multiplier / divisor.
- mthi  input  1  write data1 into HI.
- mtlo  input  1  write data1 into LO.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when new hi/lo values become visible.

Behaviour:
- Reset is asynchronous and active-high on rst, with a single clock clk.
  - rst=1 immediately forces: state IDLE, hi=0, lo=0, busy=0, done=0, counter=0, operand regs=0.
  - Reset mid-operation aborts the operation; no partial result is ever written.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter runs 0..31.
  - FINISH: busy=1, sign correction.
- IDLE -> RUN on the edge where start=1.
  - data1, data2 and op are latched at that edge; later changes to the inputs have no effect.
  - For signed ops, the operand magnitudes are latched together with the result-sign flags:
    - product sign = s1^s2;
    - quotient sign = s1^s2;
    - remainder sign = s1.
- RUN, multiply: shift-add, one multiplier bit per cycle, into a 64-bit accumulator.
- RUN, divide: restoring division, one quotient bit per cycle. Each cycle: trial-subtract the divisor from {rem, next dividend bit}; keep the result if non-negative and set the quotient bit.
- RUN -> FINISH after 32 iterations, i.e. when counter==31 at the edge.
- FINISH -> IDLE on the next edge.
  - At that edge, hi/lo are written with the sign-corrected result and done=1 for exactly that following cycle.
  - Multiply: {hi,lo} = 64-bit product.
  - Divide: lo = quotient, hi = remainder.
- Latency: start sampled at edge N.
  - busy is 1 during cycles N+1..N+33, i.e. from after edge N until edge N+33.
  - hi/lo update at edge N+33.
  - done is high between edges N+33 and N+34.
  - busy is 0 in the cycle where done=1.
- start while busy=1 is ignored. There is no queueing.
- mthi/mtlo act only in IDLE and take priority over start in the same cycle; start is then ignored.
  - mthi and mtlo together write data1 into both registers.
  - mthi/mtlo while busy are ignored.
- Divide by zero (data2=0):
  - DIVU: lo=32'hFFFFFFFF, hi=data1.
  - DIV: lo=32'hFFFFFFFF, hi=data1 unchanged in sign.
  - Same 33-cycle latency. This is a defined, deterministic result and raises no exception.
- Signed overflow (0x80000000 / -1): lo=0x80000000, hi=0.
- Magnitude of 0x80000000 is handled as unsigned 33-bit internally. No truncation is allowed.
- hi/lo hold their value in every cycle except the FINISH->IDLE edge, an IDLE mthi/mtlo edge, and reset.

Test Plan:
- Reset mid-op: start MULTU 5*7, assert rst at cycle 10 -> hi=0, lo=0, busy=0 immediately. No done pulse follows.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> at edge N+33 hi=0xFFFFFFFE, lo=0x00000001, done one cycle, busy 33 cycles.
- MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Changing data1/data2 during RUN does not alter the result.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- Division corner cases:
  - DIVU 9/0 -> lo=0xFFFFFFFF, hi=9.
  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Control interactions:
  - start asserted again while busy -> ignored, exactly one done pulse.
  - mtlo with data1=0x1234 while busy -> lo unchanged.
  - mthi in IDLE with start -> hi=data1, no operation launched.
